// File: rtl/axi4_clint_slave_if.sv
// -----------------------------------------------------------------------------
// axi4_clint_slave_if
//
// AXI4 bundle between the interconnect M00 port and the CLINT responder.
// Member names follow the flattened io_in_* port names with the io_in_
// prefix replaced by the interface instance name.
//
// Parameters:
//   ID_W  AXI ID width.
//
// Signal groups:
//   aw_*  write address (valid/ready, id, addr, len, size, burst)
//   w_*   write data    (valid/ready, data, strb, last)
//   b_*   write resp    (valid/ready, id, resp)
//   ar_*  read address  (valid/ready, id, addr, len, size, burst)
//   r_*   read data     (valid/ready, id, data, resp, last)
//
// Modports:
//   slave   the CLINT side (responder)
//   master  the initiator side (CPU / testbench)
// -----------------------------------------------------------------------------
interface axi4_clint_slave_if #(
  parameter int ID_W = 4
);
  logic            aw_valid;
  logic            aw_ready;
  logic [ID_W-1:0] aw_bits_id;
  logic [63:0]     aw_bits_addr;
  logic [7:0]      aw_bits_len;
  logic [2:0]      aw_bits_size;
  logic [1:0]      aw_bits_burst;

  logic            w_valid;
  logic            w_ready;
  logic [63:0]     w_bits_data;
  logic [7:0]      w_bits_strb;
  logic            w_bits_last;

  logic            b_valid;
  logic            b_ready;
  logic [ID_W-1:0] b_bits_id;
  logic [1:0]      b_bits_resp;

  logic            ar_valid;
  logic            ar_ready;
  logic [ID_W-1:0] ar_bits_id;
  logic [63:0]     ar_bits_addr;
  logic [7:0]      ar_bits_len;
  logic [2:0]      ar_bits_size;
  logic [1:0]      ar_bits_burst;

  logic            r_valid;
  logic            r_ready;
  logic [ID_W-1:0] r_bits_id;
  logic [63:0]     r_bits_data;
  logic [1:0]      r_bits_resp;
  logic            r_bits_last;

  modport slave (
    input  aw_valid, aw_bits_id, aw_bits_addr, aw_bits_len, aw_bits_size, aw_bits_burst,
    output aw_ready,
    input  w_valid, w_bits_data, w_bits_strb, w_bits_last,
    output w_ready,
    output b_valid, b_bits_id, b_bits_resp,
    input  b_ready,
    input  ar_valid, ar_bits_id, ar_bits_addr, ar_bits_len, ar_bits_size, ar_bits_burst,
    output ar_ready,
    output r_valid, r_bits_id, r_bits_data, r_bits_resp, r_bits_last,
    input  r_ready
  );

  modport master (
    output aw_valid, aw_bits_id, aw_bits_addr, aw_bits_len, aw_bits_size, aw_bits_burst,
    input  aw_ready,
    output w_valid, w_bits_data, w_bits_strb, w_bits_last,
    input  w_ready,
    input  b_valid, b_bits_id, b_bits_resp,
    output b_ready,
    output ar_valid, ar_bits_id, ar_bits_addr, ar_bits_len, ar_bits_size, ar_bits_burst,
    input  ar_ready,
    input  r_valid, r_bits_id, r_bits_data, r_bits_resp, r_bits_last,
    output r_ready
  );
endinterface

// File: rtl/axi4_clint_slave.sv
// -----------------------------------------------------------------------------
// axi4_clint_slave
//
// Core-local interruptor (CLINT) behind a 64-bit AXI4 responder. Holds msip,
// mtimecmp and a free-running mtime, serves read/write bursts against them
// and drives the machine timer / software interrupt lines.
//
// Register map (addr[15:0], addr[2:0] ignored):
//   0x0000 msip (bit 0), 0x4000 mtimecmp, 0xBFF8 mtime; anything else SLVERR.
//
// Ports:
//   clock    single clock, rising edge
//   reset    synchronous, active-high
//   io_in    AXI4 slave modport (aw/w/b/ar/r channels)
//   io_mtip  machine timer interrupt pending (registered mtime >= mtimecmp)
//   io_msip  machine software interrupt pending (msip bit 0)
//
// Build option:
//   CLINT_PRESCALER_EN  when defined, mtime advances once every TICK_DIV
//                       cycles; otherwise every cycle and TICK_DIV is unused.
// -----------------------------------------------------------------------------
module axi4_clint_slave #(
  parameter int ID_W     = 4,
  parameter int TICK_DIV = 100
) (
  input  logic                    clock,
  input  logic                    reset,
  axi4_clint_slave_if.slave       io_in,
  output logic                    io_mtip,
  output logic                    io_msip
);

  // Register offsets as 8-byte word indices (addr[15:3]).
  localparam logic [12:0] IDX_MSIP     = 13'h0000;
  localparam logic [12:0] IDX_MTIMECMP = 13'h0800;
  localparam logic [12:0] IDX_MTIME    = 13'h17FF;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e        w_state_q, w_state_d;
  r_state_e        r_state_q, r_state_d;

  logic [ID_W-1:0] w_id_q;
  logic [12:0]     w_idx_q;
  logic [1:0]      w_burst_q;
  logic            w_err_q;

  logic [ID_W-1:0] r_id_q;
  logic [12:0]     r_idx_q;
  logic [1:0]      r_burst_q;
  logic [7:0]      r_len_q;
  logic [7:0]      r_beat_q;
  logic [63:0]     r_data_q;
  logic [1:0]      r_resp_q;

  logic [63:0]     mtime_q;
  logic [63:0]     mtimecmp_q;
  logic            msip_q;
  logic            mtip_q;

  logic aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
  logic aw_fire, w_fire, ar_fire, r_fire;

  // Only the low word-index bits matter; everything else is tied off here.
  logic unused_ok;
  assign unused_ok = ^{io_in.aw_bits_addr[63:16], io_in.aw_bits_addr[2:0],
                       io_in.ar_bits_addr[63:16], io_in.ar_bits_addr[2:0],
                       io_in.aw_bits_len, io_in.aw_bits_size, io_in.ar_bits_size};

  function automatic logic [12:0] next_idx(input logic [12:0] idx, input logic [1:0] burst);
    return (burst == BURST_FIXED) ? idx : idx + 13'd1;
  endfunction

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) w_state_q <= W_IDLE;
    else       w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        aw_ready = 1'b1;
        if (io_in.aw_valid) w_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (io_in.w_valid && io_in.w_bits_last) w_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid = 1'b1;
        if (io_in.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // Handshake outputs are forced low while reset is held.
    if (reset) begin
      aw_ready = 1'b0;
      w_ready  = 1'b0;
      b_valid  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) r_state_q <= R_IDLE;
    else       r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        ar_ready = 1'b1;
        if (io_in.ar_valid) r_state_d = R_DATA;
      end
      R_DATA: begin
        r_valid = 1'b1;
        if (io_in.r_ready && (r_beat_q == r_len_q)) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    if (reset) begin
      ar_ready = 1'b0;
      r_valid  = 1'b0;
    end
  end

  assign r_last  = r_valid && (r_beat_q == r_len_q);
  assign aw_fire = aw_ready && io_in.aw_valid;
  assign w_fire  = w_ready  && io_in.w_valid;
  assign ar_fire = ar_ready && io_in.ar_valid;
  assign r_fire  = r_valid  && io_in.r_ready;

  // ---------------------------------------------------------------------------
  // Read decode: the beat being loaded is either the AR address (first beat)
  // or the successor of the current beat. Sampling happens on the edge that
  // presents the beat, so a same-cycle write is not yet visible.
  // ---------------------------------------------------------------------------
  logic [12:0] rd_idx;
  logic [63:0] rd_data;
  logic [1:0]  rd_resp;

  always_comb begin
    rd_idx  = (r_state_q == R_IDLE) ? io_in.ar_bits_addr[15:3] : next_idx(r_idx_q, r_burst_q);
    rd_data = 64'd0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      IDX_MSIP:     rd_data = {63'd0, msip_q};
      IDX_MTIMECMP: rd_data = mtimecmp_q;
      IDX_MTIME:    rd_data = mtime_q;
      default:      rd_resp = RESP_SLVERR;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write decode and byte-lane merge
  // ---------------------------------------------------------------------------
  logic [63:0] wmask;
  logic        wr_msip, wr_mtimecmp, wr_mtime, wr_unmapped;

  for (genvar gi = 0; gi < 8; gi++) begin : g_wmask
    assign wmask[gi*8 +: 8] = {8{io_in.w_bits_strb[gi]}};
  end

  assign wr_msip     = w_fire && (w_idx_q == IDX_MSIP);
  assign wr_mtimecmp = w_fire && (w_idx_q == IDX_MTIMECMP);
  assign wr_mtime    = w_fire && (w_idx_q == IDX_MTIME);
  assign wr_unmapped = w_fire && !(wr_msip || wr_mtimecmp || wr_mtime);

  logic [63:0] mtimecmp_merged, mtime_merged;
  assign mtimecmp_merged = (mtimecmp_q & ~wmask) | (io_in.w_bits_data & wmask);
  assign mtime_merged    = (mtime_q    & ~wmask) | (io_in.w_bits_data & wmask);

  // ---------------------------------------------------------------------------
  // Channel datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      w_id_q    <= '0;
      w_idx_q   <= '0;
      w_burst_q <= '0;
      w_err_q   <= 1'b0;
      r_id_q    <= '0;
      r_idx_q   <= '0;
      r_burst_q <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_data_q  <= '0;
      r_resp_q  <= RESP_OKAY;
    end else begin
      if (aw_fire) begin
        w_id_q    <= io_in.aw_bits_id;
        w_idx_q   <= io_in.aw_bits_addr[15:3];
        w_burst_q <= io_in.aw_bits_burst;
        w_err_q   <= 1'b0;
      end
      if (w_fire) begin
        w_idx_q <= next_idx(w_idx_q, w_burst_q);
        // Sticky: one unmapped beat makes the whole burst SLVERR.
        if (wr_unmapped) w_err_q <= 1'b1;
      end
      if (ar_fire) begin
        r_id_q    <= io_in.ar_bits_id;
        r_idx_q   <= rd_idx;
        r_burst_q <= io_in.ar_bits_burst;
        r_len_q   <= io_in.ar_bits_len;
        r_beat_q  <= 8'd0;
        r_data_q  <= rd_data;
        r_resp_q  <= rd_resp;
      end else if (r_fire && !r_last) begin
        r_idx_q  <= rd_idx;
        r_beat_q <= r_beat_q + 8'd1;
        r_data_q <= rd_data;
        r_resp_q <= rd_resp;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // CLINT registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      mtip_q     <= 1'b0;
    end else begin
      mtip_q <= (mtime_q >= mtimecmp_q);
      if (wr_mtimecmp) mtimecmp_q <= mtimecmp_merged;
      if (wr_msip && io_in.w_bits_strb[0]) msip_q <= io_in.w_bits_data[0];
    end
  end

`ifdef CLINT_PRESCALER_EN
  logic [31:0] presc_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      mtime_q <= '0;
      presc_q <= '0;
    end else if (wr_mtime) begin
      // A software write restarts the tick period as well.
      mtime_q <= mtime_merged;
      presc_q <= '0;
    end else if (presc_q == 32'(TICK_DIV - 1)) begin
      mtime_q <= mtime_q + 64'd1;
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 32'd1;
    end
  end
`else
  localparam int unused_tick_div = TICK_DIV;

  always_ff @(posedge clock) begin
    if (reset)         mtime_q <= '0;
    else if (wr_mtime) mtime_q <= mtime_merged;   // write beats the increment
    else               mtime_q <= mtime_q + 64'd1;
  end
`endif

  // ---------------------------------------------------------------------------
  // Outputs; payloads read as zero whenever their valid is low.
  // ---------------------------------------------------------------------------
  assign io_in.aw_ready    = aw_ready;
  assign io_in.w_ready     = w_ready;
  assign io_in.b_valid     = b_valid;
  assign io_in.b_bits_id   = w_id_q;
  assign io_in.b_bits_resp = (b_valid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
  assign io_in.ar_ready    = ar_ready;
  assign io_in.r_valid     = r_valid;
  assign io_in.r_bits_id   = r_id_q;
  assign io_in.r_bits_data = r_valid ? r_data_q : 64'd0;
  assign io_in.r_bits_resp = r_valid ? r_resp_q : RESP_OKAY;
  assign io_in.r_bits_last = r_last;

  assign io_mtip = mtip_q && !reset;
  assign io_msip = msip_q && !reset;

endmodule

// File: tb/tb_axi4_clint_slave.sv
// -----------------------------------------------------------------------------
// tb_axi4_clint_slave
//
// Directed bench for axi4_clint_slave (default build, no prescaler).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// The expected mtime is derived from the bench's own cycle counter, rebased on
// every reset release and on every mtime write.
// -----------------------------------------------------------------------------
module tb_axi4_clint_slave;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic io_mtip, io_msip;

  always #5 clock = ~clock;

  axi4_clint_slave_if #(.ID_W(4)) io_in ();

  axi4_clint_slave #(.ID_W(4), .TICK_DIV(100)) dut (
    .clock   (clock),
    .reset   (reset),
    .io_in   (io_in),
    .io_mtip (io_mtip),
    .io_msip (io_msip)
  );

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [1:0]  FIXED = 2'b00;
  localparam logic [1:0]  INCR  = 2'b01;
  localparam logic [3:0]  WID   = 4'h5;
  localparam logic [3:0]  RID   = 4'hA;

  int n_cmp = 0;
  int n_err = 0;
  longint unsigned cyc = 0;
  longint unsigned rel_cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mtime_now();
    return cyc - rel_cyc;
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, expected 0x%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    io_in.aw_valid = 0; io_in.aw_bits_id = WID; io_in.aw_bits_addr = 0;
    io_in.aw_bits_len = 0; io_in.aw_bits_size = 3'd3; io_in.aw_bits_burst = INCR;
    io_in.w_valid = 0; io_in.w_bits_data = 0; io_in.w_bits_strb = 0; io_in.w_bits_last = 0;
    io_in.b_ready = 0;
    io_in.ar_valid = 0; io_in.ar_bits_id = RID; io_in.ar_bits_addr = 0;
    io_in.ar_bits_len = 0; io_in.ar_bits_size = 3'd3; io_in.ar_bits_burst = INCR;
    io_in.r_ready = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    tick();
    check_eq("rst_aw_ready", io_in.aw_ready, 0);
    check_eq("rst_w_ready",  io_in.w_ready, 0);
    check_eq("rst_b_valid",  io_in.b_valid, 0);
    check_eq("rst_ar_ready", io_in.ar_ready, 0);
    check_eq("rst_r_valid",  io_in.r_valid, 0);
    check_eq("rst_r_last",   io_in.r_bits_last, 0);
    check_eq("rst_b_resp",   io_in.b_bits_resp, 0);
    check_eq("rst_r_resp",   io_in.r_bits_resp, 0);
    check_eq("rst_r_data",   io_in.r_bits_data, 0);
    check_eq("rst_mtip",     io_mtip, 0);
    check_eq("rst_msip",     io_msip, 0);
    rel_cyc = cyc;   // mtime is 0 in this cycle
    reset = 0;
    #1;
    check_eq("post_rst_aw_ready", io_in.aw_ready, 1);
    check_eq("post_rst_ar_ready", io_in.ar_ready, 1);
    check_eq("post_rst_w_ready",  io_in.w_ready, 0);
    check_eq("post_rst_b_valid",  io_in.b_valid, 0);
    $display("RESET released at cycle %0d", cyc);
  endtask

  task automatic aw_phase(input logic [63:0] addr, input logic [7:0] len, input logic [1:0] burst);
    int n = 0;
    io_in.aw_valid = 1; io_in.aw_bits_addr = addr; io_in.aw_bits_len = len;
    io_in.aw_bits_burst = burst;
    while (!io_in.aw_ready && n < 20) begin tick(); n++; end
    check_eq("aw_ready", io_in.aw_ready, 1);
    tick();
    io_in.aw_valid = 0;
  endtask

  task automatic w_beat(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int n = 0;
    io_in.w_valid = 1; io_in.w_bits_data = data; io_in.w_bits_strb = strb;
    io_in.w_bits_last = last;
    while (!io_in.w_ready && n < 20) begin tick(); n++; end
    check_eq("w_ready", io_in.w_ready, 1);
    tick();
    io_in.w_valid = 0; io_in.w_bits_last = 0;
  endtask

  task automatic b_phase(output logic [1:0] resp);
    int n = 0;
    while (!io_in.b_valid && n < 20) begin tick(); n++; end
    check_eq("b_valid", io_in.b_valid, 1);
    check_eq("b_id", io_in.b_bits_id, WID);
    resp = io_in.b_bits_resp;
    io_in.b_ready = 1;
    tick();
    io_in.b_ready = 0;
  endtask

  task automatic write1(input logic [63:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, output logic [1:0] resp);
    aw_phase(addr, 8'd0, INCR);
    w_beat(data, strb, 1'b1);
    check_eq("b_valid_lat", io_in.b_valid, 1);
    b_phase(resp);
    $display("WR addr=0x%h data=0x%h strb=0x%h resp=%0d", addr, data, strb, resp);
  endtask

  task automatic ar_phase(input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, output logic [63:0] t_cap);
    int n = 0;
    io_in.ar_valid = 1; io_in.ar_bits_addr = addr; io_in.ar_bits_len = len;
    io_in.ar_bits_burst = burst;
    while (!io_in.ar_ready && n < 20) begin tick(); n++; end
    check_eq("ar_ready", io_in.ar_ready, 1);
    t_cap = mtime_now();
    tick();
    io_in.ar_valid = 0;
    check_eq("r_valid_lat", io_in.r_valid, 1);
  endtask

  task automatic r_beat(output logic [63:0] data, output logic [1:0] resp,
                        output logic last, output logic [63:0] t_acc);
    int n = 0;
    while (!io_in.r_valid && n < 20) begin tick(); n++; end
    check_eq("r_valid", io_in.r_valid, 1);
    check_eq("r_id", io_in.r_bits_id, RID);
    data = io_in.r_bits_data; resp = io_in.r_bits_resp; last = io_in.r_bits_last;
    t_acc = mtime_now();
    io_in.r_ready = 1;
    tick();
    io_in.r_ready = 0;
  endtask

  task automatic read1(input logic [63:0] addr, output logic [63:0] data, output logic [1:0] resp);
    logic [63:0] t;
    logic last;
    ar_phase(addr, 8'd0, INCR, t);
    r_beat(data, resp, last, t);
    check_eq("rd1_last", last, 1);
    $display("RD addr=0x%h data=0x%h resp=%0d", addr, data, resp);
  endtask

  initial begin
    logic [63:0] d, tcap, tacc;
    logic [1:0]  rs;
    logic        l;
    int          n;

    do_reset();

    // mtime read with a two-cycle stall: value captured at the AR cycle.
    ar_phase(64'hBFF8, 8'd0, INCR, tcap);
    check_eq("mtime_rd", io_in.r_bits_data, tcap);
    tick(); tick();
    check_eq("mtime_hold", io_in.r_bits_data, tcap);
    r_beat(d, rs, l, tacc);
    check_eq("mtime_data", d, tcap);
    check_eq("mtime_resp", rs, 2'b00);
    check_eq("mtime_last", l, 1);
    check_eq("r_valid_drop", io_in.r_valid, 0);
    $display("RD addr=0xbff8 data=0x%h resp=%0d", d, rs);

    read1(64'h4000, d, rs);
    check_eq("mtimecmp_rst", d, ONES);
    check_eq("mtimecmp_rst_resp", rs, 2'b00);

    // msip set / clear.
    aw_phase(64'h0000, 8'd0, INCR);
    w_beat(64'd1, 8'h01, 1'b1);
    check_eq("msip_set", io_msip, 1);
    check_eq("msip_b_valid_lat", io_in.b_valid, 1);
    b_phase(rs);
    check_eq("msip_b_resp", rs, 2'b00);
    $display("WR addr=0x0000 data=0x1 strb=0x01 resp=%0d", rs);
    read1(64'h0000, d, rs);
    check_eq("msip_rd", d, 64'd1);
    write1(64'h0000, 64'd0, 8'h01, rs);
    check_eq("msip_clr", io_msip, 0);
    write1(64'h0000, 64'd1, 8'h00, rs);
    check_eq("msip_nostrb", io_msip, 0);

    // Timer interrupt edge.
    do_reset();
    write1(64'h4000, 64'h40, 8'hFF, rs);
    check_eq("cmp40_resp", rs, 2'b00);
    n = 0;
    while (mtime_now() < 64'h40 && n < 200) begin tick(); n++; end
    check_eq("mtime_reach", mtime_now(), 64'h40);
    check_eq("mtip_pre", io_mtip, 0);
    tick();
    check_eq("mtip_rise", io_mtip, 1);
    aw_phase(64'h4000, 8'd0, INCR);
    w_beat(ONES, 8'hFF, 1'b1);
    check_eq("mtip_hold", io_mtip, 1);
    b_phase(rs);
    check_eq("mtip_fall", io_mtip, 0);

    // INCR read len=1 from mtimecmp, r_ready 1,0,1.
    ar_phase(64'h4000, 8'd1, INCR, tcap);
    r_beat(d, rs, l, tacc);
    check_eq("incr_b0_data", d, ONES);
    check_eq("incr_b0_resp", rs, 2'b00);
    check_eq("incr_b0_last", l, 0);
    check_eq("incr_b1_data", io_in.r_bits_data, 0);
    tick();
    check_eq("incr_stall_valid", io_in.r_valid, 1);
    check_eq("incr_stall_data", io_in.r_bits_data, 0);
    check_eq("incr_stall_resp", io_in.r_bits_resp, 2'b10);
    r_beat(d, rs, l, tacc);
    check_eq("incr_b1_resp", rs, 2'b10);
    check_eq("incr_b1_last", l, 1);
    check_eq("incr_done", io_in.r_valid, 0);
    $display("RD addr=0x4000 len=1 beat1 data=0x%h resp=%0d", d, rs);

    // Partial strobe merge.
    write1(64'h4000, 64'h1234_5678, 8'h0F, rs);
    check_eq("strb_resp", rs, 2'b00);
    read1(64'h4000, d, rs);
    check_eq("strb_merge", d, 64'hFFFF_FFFF_1234_5678);

    // Unmapped write / read.
    write1(64'h1000, ONES, 8'hFF, rs);
    check_eq("unmapped_wr_resp", rs, 2'b10);
    read1(64'h4000, d, rs);
    check_eq("unmapped_no_change", d, 64'hFFFF_FFFF_1234_5678);
    check_eq("unmapped_msip", io_msip, 0);
    read1(64'h1000, d, rs);
    check_eq("unmapped_rd_data", d, 0);
    check_eq("unmapped_rd_resp", rs, 2'b10);

    // Two-beat INCR write: first beat unmapped, second hits mtimecmp.
    aw_phase(64'h3FF8, 8'd1, INCR);
    w_beat(64'hAAAA, 8'hFF, 1'b0);
    w_beat(64'h123, 8'hFF, 1'b1);
    check_eq("burst_b_valid_lat", io_in.b_valid, 1);
    b_phase(rs);
    check_eq("burst_wr_resp", rs, 2'b10);
    $display("WR addr=0x3ff8 len=1 resp=%0d", rs);
    read1(64'h4000, d, rs);
    check_eq("burst_wr_cmp", d, 64'h123);

    // FIXED read len=1 returns mtimecmp twice.
    ar_phase(64'h4000, 8'd1, FIXED, tcap);
    r_beat(d, rs, l, tacc);
    check_eq("fixed_b0", d, 64'h123);
    r_beat(d, rs, l, tacc);
    check_eq("fixed_b1", d, 64'h123);
    check_eq("fixed_b1_last", l, 1);
    $display("RD addr=0x4000 len=1 FIXED data=0x%h", d);

    // mtime write near the top, then read across the wrap.
    aw_phase(64'hBFF8, 8'd0, INCR);
    w_beat(64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 1'b1);
    rel_cyc = cyc - 64'hFFFF_FFFF_FFFF_FFFE;
    b_phase(rs);
    check_eq("mtime_wr_resp", rs, 2'b00);
    $display("WR addr=0xbff8 data=0xfffffffffffffffe resp=%0d", rs);
    ar_phase(64'hBFF0, 8'd1, INCR, tcap);
    r_beat(d, rs, l, tacc);
    check_eq("wrap_b0_resp", rs, 2'b10);
    r_beat(d, rs, l, tcap);
    check_eq("wrap_b1_data", d, tacc);
    check_eq("wrap_b1_resp", rs, 2'b00);
    $display("RD addr=0xbff0 len=1 beat1 data=0x%h", d);

    // Reset in the middle of a 4-beat write.
    aw_phase(64'h4000, 8'd3, INCR);
    w_beat(64'h5, 8'hFF, 1'b0);
    w_beat(64'h7, 8'hFF, 1'b0);
    do_reset();
    check_eq("abort_w_ready", io_in.w_ready, 0);
    check_eq("abort_b_valid", io_in.b_valid, 0);
    read1(64'h4000, d, rs);
    check_eq("abort_mtimecmp", d, ONES);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
